// File: rtl/mem_request_unit_pkg.sv
// Shared definitions for the memory request unit: bus geometry, the
// request FSM state type and the default instruction used after a fetch
// timeout.
package mem_request_unit_pkg;

  localparam int BUS_W  = 32;
  localparam int SEL_W  = BUS_W / 8;
  localparam int WAIT_W = 16;

  // addi x0, x0, 0
  localparam logic [BUS_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFETCH  = 2'd0,
    DECODE  = 2'd1,
    DACCESS = 2'd2,
    COMMIT  = 2'd3
  } req_state_t;

  // Kind of data access chosen in DECODE for the current instruction.
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_t;

endpackage

// File: rtl/mem_request_unit_timeout.sv
// Bus wait counter. Counts cycles spent waiting for mem_ack and flags the
// last allowed cycle (count == TIMEOUT-1). Clear has priority over enable.
module req_timeout_counter
  import mem_request_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  // Wait-cycle counter; saturates defensively although TIMEOUT bounds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_request_unit.sv
// Bridges the single-cycle core to the shared memory bus: fetch, one
// optional load/store, then a one-cycle commit strobe.
//
// Bus handshake: mem_ren / mem_wen are requests derived combinationally
// from the state and held unchanged until mem_ack. mem_ack is a one-cycle
// completion pulse; the request is complete in the cycle mem_ack is high
// (read data is sampled in that cycle). Acks outside IFETCH/DACCESS are
// ignored. A request with no ack by wait count TIMEOUT-1 is abandoned.
module mem_request_unit
  import mem_request_unit_pkg::*;
#(
  parameter int unsigned      TIMEOUT   = 255,
  parameter logic [BUS_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [BUS_W-1:0] PCaddr,
  input  logic             dmmRead,
  input  logic             dmmWrite,
  input  logic [BUS_W-1:0] dmmaddr,
  input  logic [BUS_W-1:0] dmmstore,
  input  logic [SEL_W-1:0] dmmsel,
  output logic [BUS_W-1:0] instr,
  output logic             iready,
  output logic [BUS_W-1:0] dmmLoad,
  output logic             dready,
  output logic             bus_err,
  output logic [BUS_W-1:0] mem_addr,
  output logic [BUS_W-1:0] mem_wdata,
  output logic [SEL_W-1:0] mem_sel,
  output logic             mem_ren,
  output logic             mem_wen,
  input  logic [BUS_W-1:0] mem_rdata,
  input  logic             mem_ack,
  output req_state_t       state_dbg
);

  req_state_t state_q, state_d;
  acc_kind_t  acc_q, acc_d;
  logic       tmo;
  logic       waiting;

  assign waiting   = (state_q == IFETCH) || (state_q == DACCESS);
  assign state_dbg = state_q;

  // Wait counter restarts on every state change.
  req_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (RST),
    .clear  (state_d != state_q),
    .enable (waiting),
    .tc     (tmo)
  );

  // State and access-kind registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IFETCH;
      acc_q   <= ACC_NONE;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next state; the access kind is decided once in DECODE (read wins).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IFETCH: begin
        if (mem_ack || tmo) state_d = IFETCH == IFETCH ? DECODE : IFETCH;
      end
      DECODE: begin
        if (dmmRead) begin
          acc_d   = ACC_READ;
          state_d = DACCESS;
        end else if (dmmWrite) begin
          acc_d   = ACC_WRITE;
          state_d = DACCESS;
        end else begin
          acc_d   = ACC_NONE;
          state_d = COMMIT;
        end
      end
      DACCESS: begin
        if (mem_ack || tmo) state_d = COMMIT;
      end
      COMMIT:  state_d = IFETCH;
      default: state_d = IFETCH;
    endcase
  end

  // Bus request outputs; reset forces them low without waiting for a clock.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    if (!RST) begin
      case (state_q)
        IFETCH: begin
          mem_ren  = 1'b1;
          mem_addr = PCaddr;
          mem_sel  = '1;
        end
        DACCESS: begin
          mem_addr = dmmaddr;
          mem_sel  = dmmsel;
          if (acc_q == ACC_WRITE) begin
            mem_wen   = 1'b1;
            mem_wdata = dmmstore;
          end else if (acc_q == ACC_READ) begin
            mem_ren = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign iready = (state_q == COMMIT);
  assign dready = (state_q == COMMIT) && (acc_q == ACC_READ);

  // Latched instruction, load data and sticky timeout flag.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      instr   <= '0;
      dmmLoad <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state_q == IFETCH) begin
        if (mem_ack) begin
          instr <= mem_rdata;
        end else if (tmo) begin
          instr   <= NOP_INSTR;
          bus_err <= 1'b1;
        end
      end
      if (state_q == DACCESS) begin
        if (mem_ack) begin
          if (acc_q == ACC_READ) dmmLoad <= mem_rdata;
        end else if (tmo) begin
          bus_err <= 1'b1;
          if (acc_q == ACC_READ) dmmLoad <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: each instruction is planned as a cycle
// timeline (fetch phase, decode, optional data phase, commit) from the
// wait lengths chosen for it; expected outputs per cycle go into a queue
// and one compare process checks them at the falling edge.
module tb_mem_request_unit;
  import mem_request_unit_pkg::*;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        chk_addr;
    logic        chk_wdata;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        iready;
    logic        dready;
    logic [31:0] instr;
    logic [31:0] load;
    logic        err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic [31:0]      PCaddr = '0, dmmaddr = '0, dmmstore = '0, mem_rdata = '0;
  logic             dmmRead = 1'b0, dmmWrite = 1'b0, mem_ack = 1'b0;
  logic [3:0]       dmmsel = '0;
  logic [31:0]      instr, dmmLoad, mem_addr, mem_wdata;
  logic             iready, dready, bus_err, mem_ren, mem_wen;
  logic [3:0]       mem_sel;
  req_state_t       dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  exp_t             cmp_e;
  int               n_cmp = 0;
  int               n_bad = 0;

  // Behavioural model state: what the latched outputs must hold now.
  logic [31:0]      m_instr = '0, m_load = '0;
  logic             m_err = 1'b0;

  mem_request_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .PCaddr(PCaddr), .dmmRead(dmmRead), .dmmWrite(dmmWrite),
    .dmmaddr(dmmaddr), .dmmstore(dmmstore), .dmmsel(dmmsel), .instr(instr),
    .iready(iready), .dmmLoad(dmmLoad), .dready(dready), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state_dbg(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Per-cycle compare against the planned timeline.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      n_cmp++;
      if (mem_ren !== cmp_e.ren || mem_wen !== cmp_e.wen || iready !== cmp_e.iready ||
          dready !== cmp_e.dready || instr !== cmp_e.instr || dmmLoad !== cmp_e.load ||
          bus_err !== cmp_e.err ||
          (cmp_e.chk_addr && (mem_addr !== cmp_e.addr || mem_sel !== cmp_e.sel)) ||
          (cmp_e.chk_wdata && mem_wdata !== cmp_e.wdata)) begin
        n_bad++;
        $display("FAIL cycle @%0t: got ren=%b wen=%b addr=%h sel=%h wdata=%h iready=%b dready=%b instr=%h load=%h err=%b; want ren=%b wen=%b addr=%h sel=%h wdata=%h iready=%b dready=%b instr=%h load=%h err=%b",
                 $time, mem_ren, mem_wen, mem_addr, mem_sel, mem_wdata, iready, dready,
                 instr, dmmLoad, bus_err, cmp_e.ren, cmp_e.wen, cmp_e.addr, cmp_e.sel,
                 cmp_e.wdata, cmp_e.iready, cmp_e.dready, cmp_e.instr, cmp_e.load, cmp_e.err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Expected outputs of a cycle with no bus request.
  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.instr = m_instr;
    e.load  = m_load;
    e.err   = m_err;
    return e;
  endfunction

  // Queue one cycle's expectation and advance to just after the next edge.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Non-bus cycle; a stray ack here must be ignored.
  task automatic idle(input exp_t e);
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom();
    cyc(e);
    mem_ack = 1'b0;
  endtask

  // A request that gets its ack after w wait cycles, or never if w >= TO.
  task automatic bus_phase(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s, input int w,
                           input logic [31:0] rdata, output logic acked);
    int   len;
    exp_t e;
    acked = (w < int'(TO));
    len   = acked ? w + 1 : int'(TO);
    for (int k = 1; k <= len; k++) begin
      e           = base();
      e.chk_addr  = 1'b1;
      e.chk_wdata = wr;
      e.ren       = rd;
      e.wen       = wr;
      e.addr      = a;
      e.sel       = s;
      e.wdata     = wd;
      mem_ack     = acked && (k == len);
      mem_rdata   = mem_ack ? rdata : $urandom();
      cyc(e);
    end
    mem_ack = 1'b0;
  endtask

  // Asynchronous reset in the first cycle of a pending data access.
  task automatic mid_reset(input logic [31:0] next_pc);
    #1;
    chk1("pre_reset_ren", mem_ren, 1'b1);
    RST = 1'b1;
    #1;
    chk1("async_ren_drop", mem_ren, 1'b0);
    chk1("async_wen", mem_wen, 1'b0);
    chk("async_addr", mem_addr, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_load", dmmLoad, 32'h0);
    chk1("async_err", bus_err, 1'b0);
    chk1("async_iready", iready, 1'b0);
    PCaddr = next_pc;
    repeat (2) @(posedge clk);
    #1;
    RST     = 1'b0;
    m_instr = '0;
    m_load  = '0;
    m_err   = 1'b0;
  endtask

  // One instruction. op: 0 none, 1 read, 2 write, 3 read+write.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] iword, input int wf,
                           input logic [1:0] op, input logic [31:0] daddr,
                           input logic [31:0] dstore, input logic [3:0] dsel, input int wd,
                           input logic [31:0] drdata, input logic rst_mid);
    logic acked;
    logic rd;
    exp_t e;
    PCaddr   = pc;
    dmmRead  = op[0];
    dmmWrite = op[1];
    dmmaddr  = daddr;
    dmmstore = dstore;
    dmmsel   = dsel;
    bus_phase(1'b1, 1'b0, pc, 32'h0, 4'hF, wf, iword, acked);
    m_instr = acked ? iword : NOP;
    if (!acked) m_err = 1'b1;
    idle(base());
    rd = op[0];
    if (op != 2'b00) begin
      if (rst_mid) begin
        mid_reset(pc + 32'h100);
        return;
      end
      bus_phase(rd, !rd, daddr, dstore, dsel, wd, drdata, acked);
      if (rd) m_load = acked ? drdata : 32'h0;
      if (!acked) m_err = 1'b1;
    end
    e        = base();
    e.iready = 1'b1;
    e.dready = rd;
    idle(e);
  endtask

  // Stimulus: directed cases first, then randomized instructions.
  initial begin
    int          wf, wd;
    logic [31:0] pc;

    #2;
    chk1("reset_ren", mem_ren, 1'b0);
    chk1("reset_wen", mem_wen, 1'b0);
    chk1("reset_iready", iready, 1'b0);
    chk1("reset_dready", dready, 1'b0);
    chk1("reset_err", bus_err, 1'b0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_load", dmmLoad, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IFETCH));
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;

    run_instr(32'h0, 32'h0050_0093, 0, 2'b00, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    chk("zero_wait_instr", instr, 32'h0050_0093);

    run_instr(32'h4, 32'h0400_2083, 1, 2'b01, 32'h40, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0);
    chk("load_data", dmmLoad, 32'hDEAD_BEEF);

    run_instr(32'h8, 32'h0410_2223, 0, 2'b10, 32'h44, 32'h1234_5678, 4'b0011, 0,
              32'h0, 1'b0);
    chk("load_held_after_store", dmmLoad, 32'hDEAD_BEEF);

    run_instr(32'hC, 32'hFFFF_FFFF, 100, 2'b00, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    chk("fetch_timeout_instr", instr, 32'h0000_0013);
    chk1("fetch_timeout_err", bus_err, 1'b1);

    run_instr(32'h10, 32'h0000_1111, 0, 2'b11, 32'h48, 32'h5555_AAAA, 4'hF, 1,
              32'hCAFE_F00D, 1'b0);
    chk("rw_read_wins", dmmLoad, 32'hCAFE_F00D);
    chk1("err_sticky", bus_err, 1'b1);

    run_instr(32'h14, 32'h0000_2222, 0, 2'b01, 32'h4C, 32'h0, 4'hF, 3, 32'h0BAD_0BAD, 1'b1);
    run_instr(32'h114, 32'h0000_3333, 0, 2'b00, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    chk("after_reset_instr", instr, 32'h0000_3333);
    chk1("after_reset_err", bus_err, 1'b0);

    run_instr(32'h118, 32'h0000_4444, 0, 2'b01, 32'h50, 32'h0, 4'hF, 40, 32'h1, 1'b0);
    chk("load_timeout_data", dmmLoad, 32'h0);
    chk1("load_timeout_err", bus_err, 1'b1);

    pc = 32'h200;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       wf = $urandom_range(TO, TO + 4);
        1:       wf = $urandom_range(4, TO - 1);
        default: wf = $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 9))
        0:       wd = $urandom_range(TO, TO + 4);
        1:       wd = $urandom_range(4, TO - 1);
        default: wd = $urandom_range(0, 3);
      endcase
      run_instr(pc, $urandom(), wf, 2'($urandom_range(0, 3)), $urandom(), $urandom(),
                4'($urandom_range(0, 15)), wd, $urandom(), 1'b0);
      pc = pc + 32'h4;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
